// File: rtl/decoder_or_gate_pkg.sv
// Shared constants for the decoder-based two-input gate family.
package decoder_or_gate_pkg;

    // Decoder lines per lane
    localparam int unsigned DEC_W = 4;

    // Line index for each {a, b} select value
    localparam int unsigned IDX_00 = 0;
    localparam int unsigned IDX_01 = 1;
    localparam int unsigned IDX_10 = 2;
    localparam int unsigned IDX_11 = 3;

    // Minterms that make up a | b
    localparam logic [DEC_W-1:0] OR_MASK = 4'b1110;

    // Gate function of one lane: OR of the decoder lines selected by the mask
    function automatic logic mask_reduce(input logic [DEC_W-1:0] lines,
                                         input logic [DEC_W-1:0] mask);
        return |(lines & mask);
    endfunction

endpackage

// File: rtl/dec2to4.sv
// Combinational 2-to-4 line decoder, always enabled; s[1] is operand A, s[0] is B.
module dec2to4
    import decoder_or_gate_pkg::*;
(
    input  logic [1:0]       s,
    output logic [DEC_W-1:0] y
);

    // One-hot decode of the select, two gate levels deep
    always_comb begin
        y         = '0;
        y[IDX_00] = ~s[1] & ~s[0];
        y[IDX_01] = ~s[1] &  s[0];
        y[IDX_10] =  s[1] & ~s[0];
        y[IDX_11] =  s[1] &  s[0];
    end

endmodule

// File: rtl/decoder_or_gate.sv
// Registered per-lane OR gate built from a 2-to-4 decoder; also exposes the
// registered decoder lines. Lanes are independent.
module decoder_or_gate
    import decoder_or_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       or_out,
    output logic [DEC_W*WIDTH-1:0] dec_out
);

    logic [DEC_W*WIDTH-1:0] dec_d, dec_q;
    logic [WIDTH-1:0]       or_d, or_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        dec2to4 u_dec (
            .s ({a[i], b[i]}),
            .y (dec_d[DEC_W*i +: DEC_W])
        );

        // OR is taken from the decoder lines only, never from a | b directly
        assign or_d[i] = mask_reduce(dec_d[DEC_W*i +: DEC_W], OR_MASK);
    end

    // Output flops; async reset clears both ports and drops any in-flight sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
            or_q  <= '0;
        end else begin
            dec_q <= dec_d;
            or_q  <= or_d;
        end
    end

    assign dec_out = dec_q;
    assign or_out  = or_q;

endmodule

// File: tb/tb_decoder_or_gate.sv
// Randomised self-checking bench for decoder_or_gate with 8 lanes.
module tb_decoder_or_gate;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   or_out;
    logic [4*W-1:0] dec_out;

    int checks   = 0;
    int failures = 0;

    decoder_or_gate #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .or_out  (or_out),
        .dec_out (dec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: per lane, select value 2*a+b picks which of the four lines is set
    function automatic logic [4*W-1:0] ref_dec(input logic [W-1:0] ra, input logic [W-1:0] rb);
        logic [4*W-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) begin
            int sel;
            sel = 2 * int'(ra[i]) + int'(rb[i]);
            d[4*i + sel] = 1'b1;
        end
        return d;
    endfunction

    // Every lane must hold exactly one set line
    function automatic int onehot_lanes(input logic [4*W-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            logic [3:0] lane;
            lane = d[4*i +: 4];
            if ($countones(lane) == 1) n++;
        end
        return n;
    endfunction

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge
    task automatic step_check(input string tag, input logic [W-1:0] na, input logic [W-1:0] nb);
        a = na;
        b = nb;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_or"}, 64'(or_out), 64'(na | nb));
        check_eq({tag, "_dec"}, 64'(dec_out), 64'(ref_dec(na, nb)));
    endtask

    initial begin
        rst_n = 1'b0;
        a     = '1;
        b     = '1;
        #1;
        check_eq("rst_init_or", 64'(or_out), 64'd0);
        check_eq("rst_init_dec", 64'(dec_out), 64'd0);

        // Clock runs while reset held; outputs must stay zero
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_or", 64'(or_out), 64'd0);
            check_eq("rst_hold_dec", 64'(dec_out), 64'd0);
        end

        // Release between edges: nothing changes until the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_pre_or", 64'(or_out), 64'd0);
        check_eq("rel_pre_dec", 64'(dec_out), 64'd0);
        @(negedge clk);
        check_eq("rel_post_or", 64'(or_out), 64'hff);
        check_eq("rel_post_dec", 64'(dec_out), 64'(ref_dec('1, '1)));

        // Truth table, same pattern on every lane
        step_check("tt00", 8'h00, 8'h00);
        step_check("tt01", 8'h00, 8'hff);
        step_check("tt10", 8'hff, 8'h00);
        step_check("tt11", 8'hff, 8'hff);
        check_eq("tt11_lane0", 64'(dec_out[3:0]), 64'b1000);

        // Mid-cycle input change must not reach the outputs before the edge
        step_check("mid_base", 8'h00, 8'h00);
        @(posedge clk);
        #5;
        a = 8'hff;
        b = 8'hff;
        #2;
        check_eq("mid_hold_or", 64'(or_out), 64'd0);
        @(posedge clk);
        #1;
        check_eq("mid_upd_or", 64'(or_out), 64'hff);

        // Async reset between edges clears at once; release with ab = 00 keeps zero
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_or", 64'(or_out), 64'd0);
        check_eq("async_dec", 64'(dec_out), 64'd0);
        a = '0;
        b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step_check("async_rel", 8'h00, 8'h00);

        // Independent lanes
        step_check("lanes", 8'hA5, 8'h0F);
        check_eq("lanes_or_lit", 64'(or_out), 64'hAF);
        check_eq("lanes_onehot", 64'(onehot_lanes(dec_out)), 64'(W));

        // Random regression against the previous cycle's operands
        begin
            logic [W-1:0] pa, pb;
            pa = a;
            pb = b;
            for (int n = 0; n < 1000; n++) begin
                a = W'($urandom);
                b = W'($urandom);
                @(posedge clk);
                #1;
                check_eq("rnd_or", 64'(or_out), 64'(a | b));
                check_eq("rnd_dec", 64'(dec_out), 64'(ref_dec(a, b)));
                check_eq("rnd_onehot", 64'(onehot_lanes(dec_out)), 64'(W));
                pa = a;
                pb = b;
                @(negedge clk);
                // Inputs changed after the edge must not disturb the registered value
                a = ~pa;
                b = ~pb;
                #1;
                check_eq("rnd_hold_or", 64'(or_out), 64'(pa | pb));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
